mod_sub_pipe: RTL and testbench
===============================

Name: mod_sub_pipe

Overview:
Streaming modular subtractor that computes c = (a - b) mod q, with a valid/ready handshake on both sides.
It is the inverse counterpart of the combinational mod_add and is used on the NTT/INTT datapath wherever coefficient differences are needed.
It has a two-stage pipeline, full throughput, and full backpressure support. The modulus is carried per operation, so q may change on every transfer.

Parameters:
W, 23, coefficient/modulus width in bits (package default Q_WIDTH)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, synchronous, active-high
in_valid_i  input  1  operand set valid
in_ready_o  output  1  block can accept operand set
a_i  input  W  minuend, required a_i < q_i
b_i  input  W  subtrahend, required b_i < q_i
q_i  input  W  modulus, required q_i >= 2
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
c_o  output  W  result in [0, q)

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Input transfer when in_valid_i && in_ready_o; output transfer when out_valid_o && out_ready_i.
- Stage 1 (S1) registers:
  - d1 = {1'b0,a_i} - {1'b0,b_i}, W+1 bits; MSB is the borrow.
  - q1 = q_i.
  - v1 = valid.
- Stage 2 (S2) registers:
  - c2 = borrow ? d1[W-1:0] + q1 : d1[W-1:0], truncated to W bits. The wrap is exact because a,b < q.
  - v2 = valid.
  - c_o = c2, out_valid_o = v2.
- Advance rules:
  - S2 loads when !v2 || out_ready_i.
  - S1 loads when !v1 || S2 loads.
  - in_ready_o = !rst_i && (!v1 || !v2 || out_ready_i). This is combinational from registers and out_ready_i only; no path from in_valid_i.
- Latency: 2 cycles from input transfer to out_valid_o with no stall. Throughput is 1 result per cycle.
- Backpressure: while out_valid_o && !out_ready_i, c_o and out_valid_o hold stable. The pipeline holds at most 2 results; in_ready_o falls once both stages are full.
- Simultaneous output pop and input push with both stages full: both transfers occur in the same cycle, with no bubble.
- Reset values: v1 = v2 = 0, d1 = 0, q1 = 0, c2 = 0. Hence out_valid_o = 0, c_o = 0, and in_ready_o = 0 during reset and 1 in the first cycle after.
- Reset mid-operation: all in-flight results are discarded and no partial output appears.
- Operands outside range (a >= q or b >= q): result is unspecified unless the optional range check below is enabled. The block must not hang in this case.
- Data registers may skip reset only if c_o is still forced to 0 while out_valid_o = 0.

Optional Feature:
MOD_SUB_RANGE_CHK_EN
- Defined:
  - Adds output port err_o (1 bit).
  - S1 additionally registers e1 = (a_i >= q_i) || (b_i >= q_i); e1 propagates to e2 with the same handshake.
  - err_o = e2 && out_valid_o. The result is still produced with the normal formula.
  - Reset value of err_o is 0.
- Undefined: the port and logic are absent, and the range check is the caller's responsibility.

Decomposition:
- Package mod_arith_pkg holds:
  - Q_WIDTH = 23.
  - DILITHIUM_Q = 23'd8380417.
  - typedef coeff_t = logic [Q_WIDTH-1:0].
  - This package is shared with mod_add.
- Sub-module mod_pipe_slice: a generic valid/ready register slice, parameterised by payload width.
  - Instantiated twice: the S1 payload is {e1, q1, d1}, the S2 payload is {e2, c2}.
  - The arithmetic sits combinationally between the two slices.

Test Plan:
- q=40, a=20, b=3, out_ready_i=1 -> c_o=17 with out_valid_o high exactly 2 cycles after the transfer.
- q=40: (a=20,b=21) -> 39; (a=0,b=39) -> 1; (a=0,b=0) -> 0; (a=39,b=39) -> 0.
- q=8380417: (a=0,b=1) -> 8380416; (a=8380416,b=0) -> 8380416; back-to-back each cycle -> one result per cycle, in order.
- Backpressure: hold out_ready_i=0 and present 3 operand sets -> 2 are accepted, in_ready_o=0 on the 3rd, c_o stable. Raise out_ready_i -> all 3 results drain in order with no loss or duplication.
- Reset mid-stream with 2 results in flight -> next cycle out_valid_o=0, c_o=0; the first post-reset input yields a correct result after 2 cycles.
- With MOD_SUB_RANGE_CHK_EN: q=40, a=40, b=3 -> err_o=1 alongside the result. Then a=5, b=3 -> c_o=2, err_o=0.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic constants and types for the NTT/INTT datapath.
// Used by mod_add and mod_sub_pipe.
package mod_arith_pkg;

    localparam int unsigned Q_WIDTH = 23;

    localparam logic [Q_WIDTH-1:0] DILITHIUM_Q = 23'd8380417;

    typedef logic [Q_WIDTH-1:0] coeff_t;

endpackage

// File: rtl/mod_pipe_slice.sv
// Generic valid/ready register slice: one payload register with full-throughput
// handshake. Loads whenever empty or when the downstream consumer takes the current word.
module mod_pipe_slice #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;
    logic             load;

    assign load    = !valid_q || ready_i;
    assign ready_o = load;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Payload only updates on an actual transfer so the output word stays put
    // while the slice is empty or stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage streaming modular subtractor c = (a - b) mod q with valid/ready on both sides.
// Optional operand range check (err_o) enabled by defining MOD_SUB_RANGE_CHK_EN.
module mod_sub_pipe
    import mod_arith_pkg::*;
#(
    parameter int unsigned W = Q_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] q_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
`ifdef MOD_SUB_RANGE_CHK_EN
    output logic         err_o,
`endif
    output logic [W-1:0] c_o
);

`ifdef MOD_SUB_RANGE_CHK_EN
    localparam int unsigned ErrW = 1;
`else
    localparam int unsigned ErrW = 0;
`endif

    localparam int unsigned S1W = ErrW + W + W + 1;
    localparam int unsigned S2W = ErrW + W;

    logic [W:0]     d1_in;
    logic [S1W-1:0] s1_in;
    logic [S1W-1:0] s1_out;
    logic           s1_valid;
    logic           s1_ready;

    logic [W:0]     d1;
    logic [W-1:0]   q1;
    logic           borrow;
    logic [W-1:0]   c2_in;
    logic [S2W-1:0] s2_in;
    logic [S2W-1:0] s2_out;
    logic           s2_ready;
    logic           s2_valid;

    // Stage 1 input: raw difference with the borrow kept in the extra MSB.
    assign d1_in = {1'b0, a_i} - {1'b0, b_i};

`ifdef MOD_SUB_RANGE_CHK_EN
    logic e1_in;
    logic e1;
    logic e2;

    assign e1_in = (a_i >= q_i) || (b_i >= q_i);
    assign s1_in = {e1_in, q_i, d1_in};
    assign {e1, q1, d1} = s1_out;
`else
    assign s1_in = {q_i, d1_in};
    assign {q1, d1} = s1_out;
`endif

    mod_pipe_slice #(
        .Width (S1W)
    ) u_s1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (in_valid_i),
        .ready_o (s1_ready),
        .data_i  (s1_in),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_out)
    );

    // Adding q back on a borrow wraps exactly into [0, q) because a, b < q.
    assign borrow = d1[W];
    assign c2_in  = borrow ? (d1[W-1:0] + q1) : d1[W-1:0];

`ifdef MOD_SUB_RANGE_CHK_EN
    assign s2_in = {e1, c2_in};
`else
    assign s2_in = c2_in;
`endif

    mod_pipe_slice #(
        .Width (S2W)
    ) u_s2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (s2_in),
        .valid_o (s2_valid),
        .ready_i (out_ready_i),
        .data_o  (s2_out)
    );

    assign in_ready_o  = !rst_i && s1_ready;
    assign out_valid_o = s2_valid;

`ifdef MOD_SUB_RANGE_CHK_EN
    assign {e2, c_o} = s2_out;
    assign err_o     = e2 && s2_valid;
`else
    assign c_o = s2_out;
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe: directed vector table plus handshake corner sequences.
// Range-check tests are included when MOD_SUB_RANGE_CHK_EN is defined.
module tb_mod_sub_pipe;

    localparam int unsigned W = 23;
    localparam logic [W-1:0] QD = 23'd8380417;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
`ifdef MOD_SUB_RANGE_CHK_EN
    logic         err;
`endif

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] c;
    } vec_t;

    vec_t vecs[10];
    vec_t b2b[4];
    vec_t bp[3];

    mod_sub_pipe #(
        .W (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .q_i         (q),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef MOD_SUB_RANGE_CHK_EN
        .err_o       (err),
`endif
        .c_o         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Single transfer on an empty pipeline with out_ready high; checks latency and value.
    task automatic send_one(input vec_t v, input string name);
        a = v.a; b = v.b; q = v.q; in_valid = 1'b1;
        #1;
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({name, " valid@1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({name, " valid@2"}, 32'(out_valid), 32'd1);
        check({name, " c"}, 32'(c), 32'(v.c));
    endtask

    initial begin
        int got;
        int first_cyc;
        int last_cyc;
        bit sent;

        total = 0;
        bad = 0;

        vecs[0] = '{a: 23'd20,      b: 23'd3,       q: 23'd40, c: 23'd17};
        vecs[1] = '{a: 23'd20,      b: 23'd21,      q: 23'd40, c: 23'd39};
        vecs[2] = '{a: 23'd0,       b: 23'd39,      q: 23'd40, c: 23'd1};
        vecs[3] = '{a: 23'd0,       b: 23'd0,       q: 23'd40, c: 23'd0};
        vecs[4] = '{a: 23'd39,      b: 23'd39,      q: 23'd40, c: 23'd0};
        vecs[5] = '{a: 23'd0,       b: 23'd1,       q: QD,     c: 23'd8380416};
        vecs[6] = '{a: 23'd8380416, b: 23'd0,       q: QD,     c: 23'd8380416};
        vecs[7] = '{a: 23'd5,       b: 23'd8380416, q: QD,     c: 23'd6};
        vecs[8] = '{a: 23'd0,       b: 23'd1,       q: 23'd2,  c: 23'd1};
        vecs[9] = '{a: 23'd1,       b: 23'd0,       q: 23'd2,  c: 23'd1};

        b2b[0] = '{a: 23'd0,       b: 23'd1,       q: QD, c: 23'd8380416};
        b2b[1] = '{a: 23'd8380416, b: 23'd0,       q: QD, c: 23'd8380416};
        b2b[2] = '{a: 23'd100,     b: 23'd200,     q: QD, c: 23'd8380317};
        b2b[3] = '{a: 23'd3000000, b: 23'd1000000, q: QD, c: 23'd2000000};

        bp[0] = '{a: 23'd10, b: 23'd15, q: 23'd40, c: 23'd35};
        bp[1] = '{a: 23'd7,  b: 23'd2,  q: 23'd40, c: 23'd5};
        bp[2] = '{a: 23'd0,  b: 23'd33, q: 23'd40, c: 23'd7};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; q = 23'd40;
        repeat (3) @(negedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset c", 32'(c), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);

        // Back-to-back stream: one result per cycle, in order
        got = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (out_valid) begin
                if (got < 4) check($sformatf("b2b c%0d", got), 32'(c), 32'(b2b[got].c));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (cyc < 4) begin
                a = b2b[cyc].a; b = b2b[cyc].b; q = b2b[cyc].q; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b count", 32'(got), 32'd4);
        check("b2b span", 32'(last_cyc - first_cyc), 32'd3);

        // Backpressure: two accepted, third blocked, output stable
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = bp[i].a; b = bp[i].b; q = bp[i].q; in_valid = 1'b1;
            #1;
            check($sformatf("bp in_ready%0d", i), 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        a = bp[2].a; b = bp[2].b; q = bp[2].q; in_valid = 1'b1;
        #1;
        check("bp full in_ready", 32'(in_ready), 32'd0);
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp c hold0", 32'(c), 32'(bp[0].c));
        @(negedge clk);
        #1;
        check("bp still blocked", 32'(in_ready), 32'd0);
        check("bp c hold1", 32'(c), 32'(bp[0].c));
        out_ready = 1'b1;
        #1;
        check("bp in_ready on pop", 32'(in_ready), 32'd1);
        got = 0; sent = 1'b0;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            if (out_valid) begin
                check($sformatf("bp drain c%0d", got), 32'(c), 32'(bp[got].c));
                got++;
            end
            if (in_valid && in_ready) sent = 1'b1;
            @(negedge clk);
            if (sent) in_valid = 1'b0;
            #1;
        end
        check("bp drain count", 32'(got), 32'd3);
        check("bp third accepted", 32'(sent), 32'd1);
        check("bp no duplicate", 32'(out_valid), 32'd0);

        // Reset with two results in flight
        @(negedge clk);
        out_ready = 1'b0;
        a = 23'd50; b = 23'd60; q = 23'd100; in_valid = 1'b1;
        @(negedge clk);
        a = 23'd1; b = 23'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst pre out_valid", 32'(out_valid), 32'd1);
        check("rst pre c", 32'(c), 32'd90);
        rst = 1'b1;
        #1;
        check("rst in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst c", 32'(c), 32'd0);
        @(negedge clk);
        #1;
        check("rst no stale output", 32'(out_valid), 32'd0);
        send_one('{a: 23'd30, b: 23'd45, q: 23'd100, c: 23'd85}, "post-rst");
        @(negedge clk);
        #1;
        check("post-rst drained", 32'(out_valid), 32'd0);

`ifdef MOD_SUB_RANGE_CHK_EN
        // Range check flag travels with its result
        a = 23'd40; b = 23'd3; q = 23'd40; in_valid = 1'b1;
        @(negedge clk);
        a = 23'd5; b = 23'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("err valid", 32'(out_valid), 32'd1);
        check("err flag set", 32'(err), 32'd1);
        check("err c", 32'(c), 32'd37);
        @(negedge clk);
        #1;
        check("ok valid", 32'(out_valid), 32'd1);
        check("ok flag clear", 32'(err), 32'd0);
        check("ok c", 32'(c), 32'd2);
        @(negedge clk);
        #1;
        check("err idle", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
